// File: rtl/swap_ctrl_if.sv
// Bundle between swap_ctrl and its environment: the swap request/status
// handshake plus the register-file read/write port that swap_ctrl owns.
//   slave  : swap_ctrl side (takes start/addr_a/addr_b/r_data,
//            drives r_address/w_en/w_address/w_data/busy/done)
//   master : environment side (requester plus reg_file), the mirror image
interface swap_ctrl_if #(
  parameter int unsigned N    = 7,
  parameter int unsigned BITS = 8
) ();

  logic            start;
  logic [N-1:0]    addr_a;
  logic [N-1:0]    addr_b;
  logic [BITS-1:0] r_data;
  logic [N-1:0]    r_address;
  logic            w_en;
  logic [N-1:0]    w_address;
  logic [BITS-1:0] w_data;
  logic            busy;
  logic            done;

  modport slave (
    input  start, addr_a, addr_b, r_data,
    output r_address, w_en, w_address, w_data, busy, done
  );

  modport master (
    output start, addr_a, addr_b, r_data,
    input  r_address, w_en, w_address, w_data, busy, done
  );

endinterface

// File: rtl/swap_ctrl.sv
// swap_ctrl: swaps the contents of register-file locations A and B in place
// through one BITS-wide temporary register.
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset (reg_file shares it)
//   bus   : swap_ctrl_if.slave
//           start/addr_a/addr_b : swap request, addresses captured on accept
//           r_data              : combinational read data at r_address
//           r_address, w_en, w_address, w_data : reg_file port
//           busy                : high in RD_A, RD_B, WR_B
//           done                : one-cycle pulse in FIN
// Sequence: IDLE -> RD_A (tmp <= mem[A]) -> RD_B (mem[A] <= mem[B])
//           -> WR_B (mem[B] <= tmp) -> FIN -> IDLE. Equal addresses go
//           straight from IDLE to FIN with no writes.
// Port outputs are decoded combinationally from state, a_q, b_q, tmp_q and
// r_data, because mem[B] must be forwarded to w_data in the cycle it is read.
// Optional build macro SWAP_PEND_EN: one-deep pending request slot that
// captures a start arriving while a swap is in progress and launches it
// from FIN (or from IDLE if it was captured during FIN).
module swap_ctrl #(
  parameter int unsigned N    = 7,
  parameter int unsigned BITS = 8
) (
  input  logic        clk,
  input  logic        rstn,
  swap_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_B = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [BITS-1:0] tmp_q, tmp_d;

`ifdef SWAP_PEND_EN
  logic            pend_v_q, pend_v_d;
  logic [N-1:0]    pend_a_q, pend_a_d;
  logic [N-1:0]    pend_b_q, pend_b_d;
`endif

  // Launch request from the current state's decode, applied after the case.
  logic            go;
  logic [N-1:0]    go_a;
  logic [N-1:0]    go_b;

  logic            busy;
  logic            done;
  logic            w_en;
  logic [N-1:0]    r_address;
  logic [N-1:0]    w_address;
  logic [BITS-1:0] w_data;

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      tmp_q    <= '0;
`ifdef SWAP_PEND_EN
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      pend_b_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tmp_q    <= tmp_d;
`ifdef SWAP_PEND_EN
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    tmp_d     = tmp_q;
`ifdef SWAP_PEND_EN
    pend_v_d  = pend_v_q;
    pend_a_d  = pend_a_q;
    pend_b_d  = pend_b_q;
`endif
    go        = 1'b0;
    go_a      = bus.addr_a;
    go_b      = bus.addr_b;
    busy      = 1'b0;
    done      = 1'b0;
    w_en      = 1'b0;
    r_address = a_q;
    w_address = '0;
    w_data    = '0;

    case (state_q)
      IDLE: begin
        go = bus.start;
`ifdef SWAP_PEND_EN
        // A request parked during FIN is served first; a concurrent start is dropped.
        if (pend_v_q) begin
          go       = 1'b1;
          go_a     = pend_a_q;
          go_b     = pend_b_q;
          pend_v_d = 1'b0;
        end
`endif
      end
      RD_A: begin
        busy      = 1'b1;
        r_address = a_q;
        tmp_d     = bus.r_data;
        state_d   = RD_B;
      end
      RD_B: begin
        busy      = 1'b1;
        r_address = b_q;
        w_en      = 1'b1;
        w_address = a_q;
        w_data    = bus.r_data;
        state_d   = WR_B;
      end
      WR_B: begin
        busy      = 1'b1;
        w_en      = 1'b1;
        w_address = b_q;
        w_data    = tmp_q;
        state_d   = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
`ifdef SWAP_PEND_EN
        if (pend_v_q) begin
          go       = 1'b1;
          go_a     = pend_a_q;
          go_b     = pend_b_q;
          pend_v_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (go) begin
      a_d     = go_a;
      b_d     = go_b;
      state_d = (go_a != go_b) ? RD_A : FIN;
    end

`ifdef SWAP_PEND_EN
    // Park one request that arrives while a swap is in flight.
    if (bus.start && (state_q != IDLE) && !pend_v_q) begin
      pend_v_d = 1'b1;
      pend_a_d = bus.addr_a;
      pend_b_d = bus.addr_b;
    end
`endif
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.w_en      = w_en;
  assign bus.r_address = r_address;
  assign bus.w_address = w_address;
  assign bus.w_data    = w_data;

endmodule

// File: tb/tb_swap_ctrl.sv
// Directed bench for swap_ctrl with a behavioural 128x8 register file
// (combinational read, write on rising edge, cleared by rstn).
module tb_swap_ctrl;

  localparam int unsigned N    = 7;
  localparam int unsigned BITS = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  swap_ctrl_if #(.N(N), .BITS(BITS)) bus ();

  swap_ctrl #(.N(N), .BITS(BITS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Register file model plus a backdoor write port for preloading
  logic [7:0] mem [128];
  logic       tb_we;
  logic [6:0] tb_wa;
  logic [7:0] tb_wd;
  int         wen_cnt = 0;

  assign bus.r_data = mem[bus.r_address];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else begin
      if (bus.w_en) mem[bus.w_address] <= bus.w_data;
      if (tb_we)    mem[tb_wa]         <= tb_wd;
    end
  end

  always @(posedge clk) begin
    if (bus.w_en) wen_cnt <= wen_cnt + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wr_mem(input logic [6:0] a, input logic [7:0] d);
    tb_wa = a;
    tb_wd = d;
    tb_we = 1'b1;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issue one swap from IDLE and return at the negedge where done is seen.
  // lat counts negedges after the request cycle (0 means done never came).
  task automatic run_swap(input logic [6:0] a, input logic [6:0] b,
                          output int lat, output logic busy1,
                          output logic [6:0] wa_rdb, output logic [7:0] wd_rdb,
                          output logic [6:0] wa_wrb, output logic [7:0] wd_wrb);
    lat    = 0;
    busy1  = 1'b0;
    wa_rdb = '0; wd_rdb = '0; wa_wrb = '0; wd_wrb = '0;
    bus.start  = 1'b1;
    bus.addr_a = a;
    bus.addr_b = b;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        busy1     = bus.busy;
      end
      if (i == 2) begin wa_rdb = bus.w_address; wd_rdb = bus.w_data; end
      if (i == 3) begin wa_wrb = bus.w_address; wd_wrb = bus.w_data; end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  int         lat;
  int         w0;
  int         dones;
  logic       busy1;
  logic [6:0] wa_rdb, wa_wrb;
  logic [7:0] wd_rdb, wd_wrb;
  logic [7:0] acc;

  initial begin
    tb_we      = 1'b0;
    tb_wa      = '0;
    tb_wd      = '0;
    bus.start  = 1'b0;
    bus.addr_a = '0;
    bus.addr_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_wen",   32'(bus.w_en), 32'd0);
    check("rst_raddr", 32'(bus.r_address), 32'd0);
    check("rst_waddr", 32'(bus.w_address), 32'd0);
    check("rst_wdata", 32'(bus.w_data), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: swap 3 <-> 9
    wr_mem(7'd3, 8'h11);
    wr_mem(7'd9, 8'h22);
    w0 = wen_cnt;
    run_swap(7'd3, 7'd9, lat, busy1, wa_rdb, wd_rdb, wa_wrb, wd_wrb);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_busy_rda", 32'(busy1), 32'd1);
    check("t1_rdb_waddr", 32'(wa_rdb), 32'd3);
    check("t1_rdb_wdata", 32'(wd_rdb), 32'h22);
    check("t1_wrb_waddr", 32'(wa_wrb), 32'd9);
    check("t1_wrb_wdata", 32'(wd_wrb), 32'h11);
    check("t1_fin_busy", 32'(bus.busy), 32'd0);
    check("t1_mem3", 32'(mem[3]), 32'h22);
    check("t1_mem9", 32'(mem[9]), 32'h11);
    check("t1_wen_cycles", 32'(wen_cnt - w0), 32'd2);
    @(negedge clk);
    check("t1_done_pulse", 32'(bus.done), 32'd0);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);

    // 2: A == B, no writes, done right after acceptance
    wr_mem(7'd5, 8'h5A);
    w0 = wen_cnt;
    run_swap(7'd5, 7'd5, lat, busy1, wa_rdb, wd_rdb, wa_wrb, wd_wrb);
    check("t2_latency", 32'(lat), 32'd1);
    check("t2_wen_cycles", 32'(wen_cnt - w0), 32'd0);
    check("t2_mem5", 32'(mem[5]), 32'h5A);
    @(negedge clk);

    // 3: extreme addresses
    wr_mem(7'd0,   8'hFF);
    wr_mem(7'd127, 8'h00);
    run_swap(7'd0, 7'd127, lat, busy1, wa_rdb, wd_rdb, wa_wrb, wd_wrb);
    check("t3_latency", 32'(lat), 32'd4);
    check("t3_mem0", 32'(mem[0]), 32'h00);
    check("t3_mem127", 32'(mem[127]), 32'hFF);
    @(negedge clk);

    // 4: second start during RD_B (mem[3]=0x22, mem[9]=0x11 from test 1)
    wr_mem(7'd1, 8'h33);
    wr_mem(7'd2, 8'h44);
    dones      = 0;
    bus.start  = 1'b1;
    bus.addr_a = 7'd3;
    bus.addr_b = 7'd9;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 2) begin
        check("t4_busy_rdb", 32'(bus.busy), 32'd1);
        bus.start  = 1'b1;
        bus.addr_a = 7'd1;
        bus.addr_b = 7'd2;
      end
      if (i == 3) bus.start = 1'b0;
      if (bus.done) dones++;
    end
    check("t4_mem3", 32'(mem[3]), 32'h11);
    check("t4_mem9", 32'(mem[9]), 32'h22);
`ifdef SWAP_PEND_EN
    check("t4_done_count", 32'(dones), 32'd2);
    check("t4_mem1", 32'(mem[1]), 32'h44);
    check("t4_mem2", 32'(mem[2]), 32'h33);
`else
    check("t4_done_count", 32'(dones), 32'd1);
    check("t4_mem1", 32'(mem[1]), 32'h33);
    check("t4_mem2", 32'(mem[2]), 32'h44);
`endif

    // 5: reset asserted while in WR_B
    w0         = wen_cnt;
    bus.start  = 1'b1;
    bus.addr_a = 7'd3;
    bus.addr_b = 7'd9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_wrb_wen", 32'(bus.w_en), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_wen", 32'(bus.w_en), 32'd0);
    check("t5_done", 32'(bus.done), 32'd0);
    check("t5_wen_cycles", 32'(wen_cnt - w0), 32'd1);
    acc = 8'h00;
    for (int i = 0; i < 128; i++) acc = acc | mem[i];
    check("t5_mem_clear", 32'(acc), 32'd0);
    rstn  = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("t5_no_done", 32'(dones), 32'd0);

    // 6: back-to-back swaps restore the original contents
    wr_mem(7'd3, 8'h11);
    wr_mem(7'd9, 8'h22);
    run_swap(7'd3, 7'd9, lat, busy1, wa_rdb, wd_rdb, wa_wrb, wd_wrb);
    check("t6_latency_1", 32'(lat), 32'd4);
    @(negedge clk);
    check("t6_gap_busy", 32'(bus.busy), 32'd0);
    run_swap(7'd3, 7'd9, lat, busy1, wa_rdb, wd_rdb, wa_wrb, wd_wrb);
    check("t6_latency_2", 32'(lat), 32'd4);
    check("t6_mem3", 32'(mem[3]), 32'h11);
    check("t6_mem9", 32'(mem[9]), 32'h22);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
